card_deal_controller: RTL
=========================

# card_deal_controller

Sequencer that deals a fresh board before every game. On request from the game state machine it clears the card memory, then places every colour pair at pseudo-random addresses with state "covered", and signals completion. It sits between the game state machine (`compute_colors_en` / `compute_done` handshake) and the card memory write port, which it owns while busy.

## Interface
- `ADDR_W`, 5: card address width.
- `COLOR_W`, 12: card colour width (RGB 4:4:4).
- `NUM_W`, 6: width of the card-count input.
- `MAX_CARDS`, 32: physical card slots; equal to 2**ADDR_W.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `compute_colors_en`  in  1  level request; held high by the game FSM for the whole deal.
- `num_of_cards`  in  NUM_W  requested card count; sampled once at deal start.
- `wr_en`  out  1  card memory write strobe, one write per cycle.
- `wr_addr`  out  ADDR_W  write address.
- `wr_color`  out  COLOR_W  colour written.
- `wr_state`  out  2  card state written: 2'b00 empty, 2'b01 covered.
- `busy`  out  1  high from deal start until DONE or abort.
- `compute_done`  out  1  deal complete; held while request stays high.

## Operation
- All outputs are registered. Reset value of every output is 0.
- Reset also sets the FSM to IDLE, clears the occupancy vector, and zeroes counters. The LFSR reset value is 16'hACE1.
- LFSR: 16-bit Galois, mask 16'hB400. Shift right, and XOR the mask when the outgoing LSB is 1. It advances every cycle in every state and is never reseeded, so board randomness depends on when the user presses start.
- Palette ROM: 16 entries, indices 0..15: F00, 0F0, 00F, FF0, F0F, 0FF, F80, 8F0, 08F, F08, 80F, 0F8, FFF, 888, 840, 048.
- Card-count clamp, applied at sampling: n = num_of_cards & ~1, then max(n, 2), then min(n, MAX_CARDS).
- IDLE: when compute_colors_en = 1, latch clamped n, set placed p = 0, clear address a = 0, and go to CLEAR.
- CLEAR: write wr_addr = a, wr_state = 00, wr_color = 0, and clear occupied[a]. a++. After a = MAX_CARDS-1 is written, go to PICK.
- PICK: cand = lfsr[ADDR_W-1:0], then go to PROBE. No write in this state.
- PROBE:
  - If cand ≥ n, set cand = 0 and stay.
  - Else if occupied[cand], set cand = cand+1 and stay.
  - Else go to PLACE.
- PLACE: write wr_addr = cand, wr_color = palette[p>>1], wr_state = 01, and set occupied[cand]. Then:
  - if p = n-1, go to DONE;
  - else p++ and go to PICK.
- DONE: compute_done = 1, busy = 0, no writes. When compute_colors_en = 0, go to IDLE and drop compute_done.
- Abort: compute_colors_en = 0 in any state other than IDLE or DONE sends the FSM to IDLE. wr_en is 0 from the next cycle, compute_done is never raised, and occupancy is left as is (the next deal clears it).
- p is log2(MAX_CARDS) bits wide and p>>1 indexes the palette. With n ≤ 32, every placed card has exactly one partner of the same colour.
- Every address ≥ n ends the deal at state 00 and colour 0.

## Timing
- Request first seen high at edge k: busy = 1 and the first CLEAR write (addr 0) are visible after edge k+1.
- CLEAR takes exactly MAX_CARDS cycles, with consecutive wr_en pulses on addresses 0..31 in order.
- Per card: PICK 1 cycle, then PROBE ≥ 1 cycle, then PLACE 1 cycle.
- PROBE worst case is n + MAX_CARDS cycles, so a deal is bounded by MAX_CARDS + n·(2 + n + MAX_CARDS) cycles.
- compute_done rises the cycle after the last PLACE write.
- compute_done falls the cycle after compute_colors_en is seen low.
- A re-request while in DONE (en never dropped) does not restart the deal. The request must go low for at least one cycle first.
- While busy, the write port belongs exclusively to this block. The game FSM must not write until compute_done.

## Test plan
- Reset: hold rst 3 cycles with en = 1 → all outputs 0 and FSM in IDLE. After rst is released, the LFSR sequence matches the reference model starting at 16'hACE1.
- n = 4, en held:
  - 32 writes to addresses 0..31 with state 00 and colour 0;
  - then exactly 4 writes with state 01 to distinct addresses in 0..3, colours in order F00, F00, 0F0, 0F0;
  - compute_done rises one cycle after the 4th write and holds; no writes while in DONE.
- n = 32: 32 placements to distinct addresses covering 0..31, 16 colour pairs (palette 0..15, each exactly twice). Total deal cycles match the cycle-accurate model and stay within the bound.
- Clamp:
  - num_of_cards = 5 → 4 placements;
  - 0 → 2;
  - 1 → 2;
  - 6'd40 → 32.
  - Changing num_of_cards mid-deal has no effect.
- Abort: drop en during PROBE of the 3rd card → wr_en 0 from the next cycle, compute_done stays 0, busy 0. Re-asserting en restarts with a full 32-cycle CLEAR.
- Handshake: in DONE, pulse en low for one cycle → compute_done falls one cycle later. The new request starts a new deal whose placements differ from the previous deal, because the LFSR kept running.

Source files
------------

// File: rtl/card_deal_controller.sv
// card_deal_controller
// Deals a fresh board: clears the card memory, then places every colour pair
// at pseudo-random free addresses as "covered", and signals completion.
// Owns the card memory write port from deal start until done or abort.
module card_deal_controller #(
    parameter int ADDR_W    = 5,
    parameter int COLOR_W   = 12,
    parameter int NUM_W     = 6,
    parameter int MAX_CARDS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compute_colors_en,
    input  logic [NUM_W-1:0]   num_of_cards,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [COLOR_W-1:0] wr_color,
    output logic [1:0]         wr_state,
    output logic               busy,
    output logic               compute_done
);

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int          CNT_W     = ADDR_W + 1;

    localparam logic [1:0]  CARD_EMPTY   = 2'b00;
    localparam logic [1:0]  CARD_COVERED = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_PICK  = 3'd2,
        S_PROBE = 3'd3,
        S_PLACE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [15:0]            r_lfsr;
    logic [MAX_CARDS-1:0]   r_occ;
    logic [CNT_W-1:0]       r_n;
    logic [ADDR_W-1:0]      r_p;
    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      r_cand;

    logic [31:0]            w_req_even;
    logic [CNT_W-1:0]       w_n_clamped;
    logic                   w_abort;
    logic                   w_last_addr;
    logic                   w_last_card;
    logic                   w_cand_oob;
    logic [3:0]             w_pal_idx;
    logic [COLOR_W-1:0]     w_pal_color;

    logic                   w_wr_en;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [COLOR_W-1:0]     w_wr_color;
    logic [1:0]             w_wr_state;
    logic                   w_busy;
    logic                   w_done;

    // Colour pair palette, indexed by pair number
    function automatic logic [COLOR_W-1:0] palette(input logic [3:0] idx);
        logic [11:0] c;
        case (idx)
            4'd0:    c = 12'hF00;
            4'd1:    c = 12'h0F0;
            4'd2:    c = 12'h00F;
            4'd3:    c = 12'hFF0;
            4'd4:    c = 12'hF0F;
            4'd5:    c = 12'h0FF;
            4'd6:    c = 12'hF80;
            4'd7:    c = 12'h8F0;
            4'd8:    c = 12'h08F;
            4'd9:    c = 12'hF08;
            4'd10:   c = 12'h80F;
            4'd11:   c = 12'h0F8;
            4'd12:   c = 12'hFFF;
            4'd13:   c = 12'h888;
            4'd14:   c = 12'h840;
            default: c = 12'h048;
        endcase
        return COLOR_W'(c);
    endfunction

    // Clamp the requested count to an even value in [2, MAX_CARDS]
    always_comb begin
        w_req_even = 32'(num_of_cards) & ~32'd1;
        if (w_req_even < 32'd2) begin
            w_n_clamped = CNT_W'(2);
        end else if (w_req_even > 32'(MAX_CARDS)) begin
            w_n_clamped = CNT_W'(MAX_CARDS);
        end else begin
            w_n_clamped = CNT_W'(w_req_even);
        end
    end

    assign w_abort     = (r_state != S_IDLE) && (r_state != S_DONE) && !compute_colors_en;
    assign w_last_addr = (r_addr == ADDR_W'(MAX_CARDS - 1));
    assign w_last_card = (CNT_W'(r_p) == (r_n - CNT_W'(1)));
    assign w_cand_oob  = (CNT_W'(r_cand) >= r_n);
    assign w_pal_idx   = 4'(r_p >> 1);
    assign w_pal_color = palette(w_pal_idx);

    // Free-running Galois LFSR; never reseeded so boards depend on start time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and pre-register output values; an abort overrides everything
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = '0;
        w_wr_color   = '0;
        w_wr_state   = CARD_EMPTY;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (compute_colors_en) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_busy    = 1'b1;
                w_wr_en   = 1'b1;
                w_wr_addr = r_addr;
                if (w_last_addr) begin
                    w_next_state = S_PICK;
                end
            end
            S_PICK: begin
                w_busy       = 1'b1;
                w_next_state = S_PROBE;
            end
            S_PROBE: begin
                w_busy = 1'b1;
                if (!w_cand_oob && !r_occ[r_cand]) begin
                    w_next_state = S_PLACE;
                end
            end
            S_PLACE: begin
                w_busy       = 1'b1;
                w_wr_en      = 1'b1;
                w_wr_addr    = r_cand;
                w_wr_color   = w_pal_color;
                w_wr_state   = CARD_COVERED;
                w_next_state = w_last_card ? S_DONE : S_PICK;
            end
            S_DONE: begin
                if (compute_colors_en) begin
                    w_done = 1'b1;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        // Abort squashes the registered outputs of this cycle so the write
        // strobe is already low on the cycle after the request drops.
        if (w_abort) begin
            w_next_state = S_IDLE;
            w_wr_en      = 1'b0;
            w_wr_addr    = '0;
            w_wr_color   = '0;
            w_wr_state   = CARD_EMPTY;
            w_busy       = 1'b0;
        end
    end

    // Deal datapath: count, clear address, candidate search, occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n    <= '0;
            r_p    <= '0;
            r_addr <= '0;
            r_cand <= '0;
            r_occ  <= '0;
        end else if (!w_abort) begin
            case (r_state)
                S_IDLE: begin
                    if (compute_colors_en) begin
                        r_n    <= w_n_clamped;
                        r_p    <= '0;
                        r_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_occ[r_addr] <= 1'b0;
                    r_addr        <= r_addr + ADDR_W'(1);
                end
                S_PICK: begin
                    r_cand <= r_lfsr[ADDR_W-1:0];
                end
                S_PROBE: begin
                    if (w_cand_oob) begin
                        r_cand <= '0;
                    end else if (r_occ[r_cand]) begin
                        r_cand <= r_cand + ADDR_W'(1);
                    end
                end
                S_PLACE: begin
                    r_occ[r_cand] <= 1'b1;
                    if (!w_last_card) begin
                        r_p <= r_p + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_color     <= '0;
            wr_state     <= 2'b00;
            busy         <= 1'b0;
            compute_done <= 1'b0;
        end else begin
            wr_en        <= w_wr_en;
            wr_addr      <= w_wr_addr;
            wr_color     <= w_wr_color;
            wr_state     <= w_wr_state;
            busy         <= w_busy;
            compute_done <= w_done;
        end
    end

endmodule
